dac_write_arbiter: RTL and testbench

- Shares the dual-channel 8-bit parallel DAC write bus (CSn/WRn/A_B/LDACn/D) between two independent requesters, one per DAC channel (A and B).
- Arbitrates round-robin, latches the winning data, then sequences one timed write cycle: setup, WR pulse, hold, then an inter-write gap.
- Optional synchronous-load mode: LDACn pulses only after both channels have fresh data, so A and B outputs update together.
- Sits between button/LUT/waveform sources and the DAC pins; replaces ad-hoc free-running write loops.

---
 rtl/dac_write_arbiter_if.sv | 30 +++
 rtl/dac_write_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dac_write_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_write_arbiter_if.sv
// rtl/dac_write_arbiter_if.sv - requester handshakes and DAC pin bundle
// The arbiter uses the slave modport; requesters/pin consumers use master.
interface dac_write_arbiter_if;
   logic       req_a;
   logic [7:0] data_a;
   logic       ack_a;
   logic       req_b;
   logic [7:0] data_b;
   logic       ack_b;
   logic       dac_csn;
   logic       dac_wrn;
   logic       dac_a_b;
   logic       dac_ldacn;
   logic [7:0] dac_d;
   logic       busy;
   logic [7:0] last_a;
   logic [7:0] last_b;

   modport slave (
      input  req_a, data_a, req_b, data_b,
      output ack_a, ack_b, dac_csn, dac_wrn, dac_a_b, dac_ldacn, dac_d,
             busy, last_a, last_b
   );

   modport master (
      output req_a, data_a, req_b, data_b,
      input  ack_a, ack_b, dac_csn, dac_wrn, dac_a_b, dac_ldacn, dac_d,
             busy, last_a, last_b
   );
endinterface

// File: rtl/dac_write_arbiter.sv
// rtl/dac_write_arbiter.sv - round-robin two-channel arbiter and timed DAC write sequencer
// One grant per write cycle: SETUP -> WRITE -> HOLD -> GAP, optional paired LDAC update.
module dac_write_arbiter #(
   parameter int SETUP_CYC = 30,
   parameter int WR_CYC    = 50,
   parameter int HOLD_CYC  = 30,
   parameter int GAP_CYC   = 200,
   parameter int SYNC_LOAD = 0,
   parameter int LDAC_CYC  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   dac_write_arbiter_if.slave   bus
);
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WRITE, S_HOLD, S_GAP} state_t;

   localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
   localparam logic [7:0] WR_LAST    = 8'(WR_CYC - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);
   localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);
   localparam logic [7:0] LDAC_LAST  = 8'(LDAC_CYC - 1);
   localparam logic       LDACN_RST  = (SYNC_LOAD != 0);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       rr_b_q, rr_b_d;
   logic       pend_a_q, pend_a_d, pend_b_q, pend_b_d;
   logic       csn_q, csn_d, wrn_q, wrn_d, a_b_q, a_b_d, ldacn_q, ldacn_d;
   logic [7:0] d_q, d_d, last_a_q, last_a_d, last_b_q, last_b_d;
   logic       ack_a_q, ack_a_d, ack_b_q, ack_b_d, busy_q, busy_d;
   logic       grant_b, pend_a_nx, pend_b_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 8'd0;
         rr_b_q   <= 1'b0;
         pend_a_q <= 1'b0;
         pend_b_q <= 1'b0;
         csn_q    <= 1'b1;
         wrn_q    <= 1'b1;
         a_b_q    <= 1'b0;
         ldacn_q  <= LDACN_RST;
         d_q      <= 8'h80;
         last_a_q <= 8'h80;
         last_b_q <= 8'h80;
         ack_a_q  <= 1'b0;
         ack_b_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rr_b_q   <= rr_b_d;
         pend_a_q <= pend_a_d;
         pend_b_q <= pend_b_d;
         csn_q    <= csn_d;
         wrn_q    <= wrn_d;
         a_b_q    <= a_b_d;
         ldacn_q  <= ldacn_d;
         d_q      <= d_d;
         last_a_q <= last_a_d;
         last_b_q <= last_b_d;
         ack_a_q  <= ack_a_d;
         ack_b_q  <= ack_b_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 8'd1;
      rr_b_d    = rr_b_q;
      pend_a_d  = pend_a_q;
      pend_b_d  = pend_b_q;
      csn_d     = csn_q;
      wrn_d     = wrn_q;
      a_b_d     = a_b_q;
      ldacn_d   = ldacn_q;
      d_d       = d_q;
      last_a_d  = last_a_q;
      last_b_d  = last_b_q;
      ack_a_d   = 1'b0;
      ack_b_d   = 1'b0;
      grant_b   = 1'b0;
      pend_a_nx = pend_a_q;
      pend_b_nx = pend_b_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = 8'd0;
            if (bus.req_a || bus.req_b) begin
               // The pointer only moves when both sides actually competed.
               grant_b = bus.req_b && (!bus.req_a || rr_b_q);
               if (bus.req_a && bus.req_b) rr_b_d = !grant_b;
               state_d = S_SETUP;
               csn_d   = 1'b0;
               a_b_d   = grant_b;
               d_d     = grant_b ? bus.data_b : bus.data_a;
               ack_a_d = !grant_b;
               ack_b_d = grant_b;
            end
         end
         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = S_WRITE;
               cnt_d   = 8'd0;
               wrn_d   = 1'b0;
            end
         end
         S_WRITE: begin
            if (cnt_q == WR_LAST) begin
               state_d = S_HOLD;
               cnt_d   = 8'd0;
               wrn_d   = 1'b1;
            end
         end
         S_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = S_GAP;
               cnt_d   = 8'd0;
               csn_d   = 1'b1;
               if (a_b_q) last_b_d = d_q;
               else       last_a_d = d_q;
               if (SYNC_LOAD != 0) begin
                  pend_a_nx = pend_a_q || !a_b_q;
                  pend_b_nx = pend_b_q || a_b_q;
                  if (pend_a_nx && pend_b_nx) begin
                     ldacn_d  = 1'b0;
                     pend_a_d = 1'b0;
                     pend_b_d = 1'b0;
                  end else begin
                     pend_a_d = pend_a_nx;
                     pend_b_d = pend_b_nx;
                  end
               end
            end
         end
         S_GAP: begin
            if ((SYNC_LOAD != 0) && (cnt_q == LDAC_LAST)) ldacn_d = 1'b1;
            if (cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
               cnt_d   = 8'd0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign bus.ack_a     = ack_a_q;
   assign bus.ack_b     = ack_b_q;
   assign bus.dac_csn   = csn_q;
   assign bus.dac_wrn   = wrn_q;
   assign bus.dac_a_b   = a_b_q;
   assign bus.dac_ldacn = ldacn_q;
   assign bus.dac_d     = d_q;
   assign bus.busy      = busy_q;
   assign bus.last_a    = last_a_q;
   assign bus.last_b    = last_b_q;
endmodule

// File: tb/tb_dac_write_arbiter.sv
// tb/tb_dac_write_arbiter.sv - self-checking bench for dac_write_arbiter
// Two DUTs (SYNC_LOAD 0 and 1) share stimulus and are checked against a timeline model.
module tb_dac_write_arbiter;
   localparam int S    = 2;
   localparam int W    = 3;
   localparam int H    = 2;
   localparam int G    = 4;
   localparam int L    = 4;
   localparam int T    = 1 + S + W + H + G;
   localparam int GAP0 = S + W + H;

   typedef struct {
      logic       ra;
      logic [7:0] da;
      logic       rb;
      logic [7:0] db;
      logic       ch;
      logic [7:0] d;
      logic [7:0] la;
      logic [7:0] lb;
      int         pulse;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_a, req_b;
   logic [7:0] data_a, data_b;
   int         n_checks = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   dac_write_arbiter_if bus0();
   dac_write_arbiter_if bus1();

   assign bus0.req_a  = req_a;
   assign bus0.data_a = data_a;
   assign bus0.req_b  = req_b;
   assign bus0.data_b = data_b;
   assign bus1.req_a  = req_a;
   assign bus1.data_a = data_a;
   assign bus1.req_b  = req_b;
   assign bus1.data_b = data_b;

   dac_write_arbiter #(.SETUP_CYC(S), .WR_CYC(W), .HOLD_CYC(H), .GAP_CYC(G),
                       .SYNC_LOAD(0), .LDAC_CYC(L))
      dut0 (.clk(clk), .rst(rst), .bus(bus0));

   dac_write_arbiter #(.SETUP_CYC(S), .WR_CYC(W), .HOLD_CYC(H), .GAP_CYC(G),
                       .SYNC_LOAD(1), .LDAC_CYC(L))
      dut1 (.clk(clk), .rst(rst), .bus(bus1));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference: everything derives from cycles elapsed since the last grant.
   int         m_el;
   logic       m_ch, m_ptr, m_pa, m_pb, m_pulse;
   logic [7:0] m_d, m_la, m_lb;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_el = 1000; m_ch = 0; m_ptr = 0; m_pa = 0; m_pb = 0; m_pulse = 0;
         m_d = 8'h80; m_la = 8'h80; m_lb = 8'h80;
      end else begin
         if (m_el < 1000) m_el++;
         if (m_el >= T && (req_a || req_b)) begin
            m_ch = (req_a && req_b) ? m_ptr : req_b;
            if (req_a && req_b) m_ptr = !m_ch;
            m_d  = m_ch ? data_b : data_a;
            m_el = 0;
         end
         if (m_el == GAP0) begin
            if (m_ch) begin m_lb = m_d; m_pb = 1; end
            else      begin m_la = m_d; m_pa = 1; end
            m_pulse = m_pa && m_pb;
            if (m_pulse) begin m_pa = 0; m_pb = 0; end
         end
      end
   end

   always @(negedge clk) begin
      logic [30:0] e0, e1, a0, a1;
      logic        csn, wrn, aa, ab, bsy, ld1;
      csn = !(m_el < GAP0);
      wrn = !(m_el >= S && m_el < S + W);
      aa  = (m_el == 0) && !m_ch;
      ab  = (m_el == 0) && m_ch;
      bsy = m_el < T - 1;
      ld1 = !(m_pulse && m_el >= GAP0 && m_el < GAP0 + L);
      e0 = {csn, wrn, m_ch, 1'b0, m_d, aa, ab, bsy, m_la, m_lb};
      e1 = {csn, wrn, m_ch, ld1,  m_d, aa, ab, bsy, m_la, m_lb};
      a0 = {bus0.dac_csn, bus0.dac_wrn, bus0.dac_a_b, bus0.dac_ldacn, bus0.dac_d,
            bus0.ack_a, bus0.ack_b, bus0.busy, bus0.last_a, bus0.last_b};
      a1 = {bus1.dac_csn, bus1.dac_wrn, bus1.dac_a_b, bus1.dac_ldacn, bus1.dac_d,
            bus1.ack_a, bus1.ack_b, bus1.busy, bus1.last_a, bus1.last_b};
      chk("cycle_sync0", 64'(a0), 64'(e0));
      chk("cycle_sync1", 64'(a1), 64'(e1));
   end

   task automatic set_req(input logic ra, input logic [7:0] da, input logic rb, input logic [7:0] db);
      req_a = ra; data_a = da; req_b = rb; data_b = db;
   endtask

   task automatic wait_ack(output logic ch, output int waited);
      ch = 0; waited = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus0.ack_a || bus0.ack_b) begin
            ch = bus0.ack_b; waited = i;
            break;
         end
      end
      if (waited < 0) chk("ack_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_idle(output int ldac_lo);
      bit done;
      ldac_lo = 0; done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (!bus0.busy) done = 1;
         else begin
            if (!bus1.dac_ldacn) ldac_lo++;
            @(negedge clk);
         end
      end
      if (!done) chk("idle_timeout", 64'd0, 64'd1);
   endtask

   task automatic one_write(input logic ra, input logic [7:0] da, input logic rb,
                            input logic [7:0] db, output logic ch);
      int w, lo;
      set_req(ra, da, rb, db);
      wait_ack(ch, w);
      set_req(0, da, 0, db);
      wait_idle(lo);
   endtask

   initial begin
      vec_t vecs[8];
      logic ch;
      int   w, lo, csn_lo, wrn_lo, first;

      vecs[0] = '{1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h3C, 8'h80, 0};
      vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h40, 1'b1, 8'h40, 8'h3C, 8'h40, 4};
      vecs[2] = '{1'b1, 8'h10, 1'b1, 8'hF0, 1'b0, 8'h10, 8'h10, 8'h40, 0};
      vecs[3] = '{1'b1, 8'h11, 1'b1, 8'hF1, 1'b1, 8'hF1, 8'h10, 8'hF1, 4};
      vecs[4] = '{1'b1, 8'h20, 1'b0, 8'h00, 1'b0, 8'h20, 8'h20, 8'hF1, 0};
      vecs[5] = '{1'b1, 8'h21, 1'b0, 8'h00, 1'b0, 8'h21, 8'h21, 8'hF1, 0};
      vecs[6] = '{1'b0, 8'h00, 1'b1, 8'h40, 1'b1, 8'h40, 8'h21, 8'h40, 4};
      vecs[7] = '{1'b1, 8'h55, 1'b1, 8'hAA, 1'b0, 8'h55, 8'h55, 8'h40, 0};

      rst = 1'b1;
      set_req(0, 8'h00, 0, 8'h00);
      repeat (3) @(negedge clk);
      chk("rst_csn", 64'(bus0.dac_csn), 64'd1);
      chk("rst_d", 64'(bus0.dac_d), 64'h80);
      chk("rst_ldacn_sync1", 64'(bus1.dac_ldacn), 64'd1);
      chk("rst_ldacn_sync0", 64'(bus0.dac_ldacn), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         set_req(vecs[i].ra, vecs[i].da, vecs[i].rb, vecs[i].db);
         wait_ack(ch, w);
         chk($sformatf("vec%0d_ch", i), 64'(ch), 64'(vecs[i].ch));
         chk($sformatf("vec%0d_d", i), 64'(bus0.dac_d), 64'(vecs[i].d));
         set_req(0, vecs[i].da, 0, vecs[i].db);
         wait_idle(lo);
         chk($sformatf("vec%0d_last_a", i), 64'(bus0.last_a), 64'(vecs[i].la));
         chk($sformatf("vec%0d_last_b", i), 64'(bus1.last_b), 64'(vecs[i].lb));
         chk($sformatf("vec%0d_ldac_low", i), 64'(lo), 64'(vecs[i].pulse));
      end

      // Asynchronous reset in the middle of the WR pulse
      set_req(1, 8'h5A, 0, 8'h00);
      wait_ack(ch, w);
      set_req(0, 8'h5A, 0, 8'h00);
      repeat (3) @(negedge clk);
      chk("pre_reset_wrn", 64'(bus0.dac_wrn), 64'd0);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_csn", 64'(bus0.dac_csn), 64'd1);
      chk("async_rst_wrn", 64'(bus0.dac_wrn), 64'd1);
      chk("async_rst_d", 64'(bus0.dac_d), 64'h80);
      chk("async_rst_busy", 64'(bus0.busy), 64'd0);
      chk("async_rst_ack", 64'({bus0.ack_a, bus0.ack_b}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      lo = 0;
      repeat (20) begin
         @(negedge clk);
         if (!bus0.dac_csn) lo++;
      end
      chk("idle_after_reset", 64'(lo), 64'd0);

      // Single A write pin timing
      set_req(1, 8'h3C, 0, 8'h00);
      wait_ack(ch, w);
      set_req(0, 8'h3C, 0, 8'h00);
      csn_lo = 0; wrn_lo = 0; first = -1;
      for (int i = 0; i < 16; i++) begin
         if (!bus0.dac_csn) csn_lo++;
         if (!bus0.dac_wrn) begin
            wrn_lo++;
            if (first < 0) first = i;
         end
         @(negedge clk);
      end
      chk("single_csn_low", 64'(csn_lo), 64'd7);
      chk("single_wrn_low", 64'(wrn_lo), 64'd3);
      chk("single_wrn_start", 64'(first), 64'd2);
      chk("single_last_a", 64'(bus0.last_a), 64'h3C);

      // Contention with both requests held
      set_req(1, 8'h10, 1, 8'hF0);
      for (int g = 0; g < 4; g++) begin
         wait_ack(ch, w);
         chk($sformatf("cont%0d_ch", g), 64'(ch), 64'(g % 2));
         chk($sformatf("cont%0d_one_ack", g), 64'(bus0.ack_a & bus0.ack_b), 64'd0);
         chk($sformatf("cont%0d_d", g), 64'(bus0.dac_d), (g % 2) ? 64'hF0 : 64'h10);
         if (g > 0) chk($sformatf("cont%0d_spacing", g), 64'(w + 1), 64'(T));
      end
      set_req(0, 8'h00, 0, 8'h00);
      wait_idle(lo);

      // Pointer fairness: lone requests never move the pointer
      for (int k = 0; k < 3; k++) one_write(0, 8'h00, 1, 8'(8'hB0 + k), ch);
      one_write(1, 8'h61, 1, 8'h62, ch);
      chk("fair_first_a", 64'(ch), 64'd0);
      for (int k = 0; k < 3; k++) one_write(0, 8'h00, 1, 8'(8'hC0 + k), ch);
      one_write(1, 8'h71, 1, 8'h72, ch);
      chk("fair_then_b", 64'(ch), 64'd1);

      // Back-to-back: request held past ack with new data
      set_req(1, 8'h01, 0, 8'h00);
      wait_ack(ch, w);
      data_a = 8'h02;
      wait_ack(ch, w);
      chk("b2b_spacing", 64'(w + 1), 64'(T));
      chk("b2b_d", 64'(bus0.dac_d), 64'h02);
      set_req(0, 8'h00, 0, 8'h00);
      wait_idle(lo);

      // Random traffic, checked cycle by cycle against the model
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         if (bus0.ack_a) begin
            if ($urandom_range(1, 0) == 0) req_a = 0;
            else data_a = 8'($urandom);
         end else if (!req_a) begin
            if ($urandom_range(3, 0) == 0) begin req_a = 1; data_a = 8'($urandom); end
         end else if ($urandom_range(7, 0) == 0) data_a = 8'($urandom);
         if (bus0.ack_b) begin
            if ($urandom_range(1, 0) == 0) req_b = 0;
            else data_b = 8'($urandom);
         end else if (!req_b) begin
            if ($urandom_range(3, 0) == 0) begin req_b = 1; data_b = 8'($urandom); end
         end else if ($urandom_range(7, 0) == 0) data_b = 8'($urandom);
      end
      @(negedge clk);
      set_req(0, 8'h00, 0, 8'h00);
      wait_idle(lo);
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
